// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin sequencer sharing one 32-bit ALU
module alu (
  input  logic [2:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  // Any shift amount of 32 or more saturates; only the low five bits steer the barrel shifter
  logic        big_shift;
  logic [31:0] sra;

  assign big_shift = |b[31:5];
  // Kept as a separate net so the unsigned saturation value cannot turn the shift logical
  assign sra = $signed(a) >>> b[4:0];

  // Operation select
  always_comb begin
    y = '0;
    case (ctrl)
      3'b000: y = a + b;
      3'b001: y = a - b;
      3'b010: y = a & b;
      3'b011: y = a | b;
      3'b100: y = a ^ b;
      3'b101: y = big_shift ? 32'd0 : (a << b[4:0]);
      3'b110: y = big_shift ? 32'd0 : (a >> b[4:0]);
      3'b111: y = big_shift ? {32{a[31]}} : sra;
      default: y = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last;
  logic             port;
  logic [2:0]       op_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] alu_y;
  logic             grant1;
  logic             rsp_taken;

  // Port 1 wins when it is the only requester, or when both ask and port 0 was served last
  assign grant1     = req1_valid && (!req0_valid || !last);
  assign req0_ready = (state == IDLE) && req0_valid && !grant1;
  assign req1_ready = (state == IDLE) && grant1;

  // Only the granted port's consumer can complete the response
  assign rsp_taken  = port ? rsp1_ready : rsp0_ready;

  assign rsp0_valid = (state == RESP) && !port;
  assign rsp1_valid = (state == RESP) && port;
  assign rsp0_data  = result;
  assign rsp1_data  = result;
  assign busy       = (state != IDLE);

  alu u_alu (
    .ctrl (op_ctrl),
    .a    (op_a),
    .b    (op_b),
    .y    (alu_y)
  );

  // Sequencer: accept one request, run it through the ALU, hold the result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      port    <= 1'b0;
      op_ctrl <= '0;
      op_a    <= '0;
      op_b    <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            op_ctrl <= grant1 ? req1_ctrl : req0_ctrl;
            op_a    <= grant1 ? req1_a : req0_a;
            op_b    <= grant1 ? req1_b : req0_b;
            port    <= grant1;
            last    <= grant1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          result <= alu_y;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_taken) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares one 32-bit `alu` (ctrl 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr logical, 111 shr arithmetic) between two requesters. It accepts one operation at a time through a valid/ready request channel and registers the operands. It runs the operation through the instantiated `alu` and returns the registered result on the response channel of the granting port. It sits between the instruction-issue logic and the shared ALU resource.

## Interface
- `WIDTH`, 32, datapath width; only 32 is supported, fixed by `alu`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  each: request pending on port n.
- `req0_ready`, `req1_ready`  out  1  each: request accepted this cycle on port n.
- `req0_ctrl`, `req1_ctrl`  in  3  each: ALU operation code.
- `req0_a`, `req1_a`  in  WIDTH  each: operand a, signed.
- `req0_b`, `req1_b`  in  WIDTH  each: operand b, signed.
- `rsp0_valid`, `rsp1_valid`  out  1  each: result available on port n.
- `rsp0_ready`, `rsp1_ready`  in  1  each: consumer takes the result on port n.
- `rsp0_data`, `rsp1_data`  out  WIDTH  each: result for port n.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - If no `reqN_valid` is high, the FSM stays in IDLE.
  - Otherwise it selects one port (the grant) and asserts `reqN_ready` for that port only. `reqN_ready` is combinational from state, valid inputs and the priority pointer.
  - On the accepting edge it latches ctrl, a, b and the port id, then moves to EXEC.
- **Arbitration** is round-robin using a 1-bit pointer `last`:
  - Both valid: the port != `last` wins.
  - One valid: that port wins regardless of `last`.
  - `last` updates to the granted port on accept.
  - Reset value of `last` is 1, so port 0 wins the first contention.
- **EXEC**
  - Latched operands drive `alu`.
  - The `alu` output is registered into the result register on the edge, and the FSM moves to RESP.
- **RESP**
  - `rspN_valid` is high for the latched port only. The same value appears on both `rspN_data` outputs; only the granted port is valid.
  - The FSM holds in RESP until `rspN_ready` is high on the granted port, then returns to IDLE.
  - No request is accepted while in EXEC or RESP; both `reqN_ready` stay 0.
- **Arithmetic**
  - All results are modulo 2^32.
  - Shift amount is the full b treated as unsigned.
  - For b >= 32: shl and shr give 0; shr arithmetic gives 0 or all-ones depending on the sign of a.
  - Arithmetic shift uses signed a.
- **Request protocol**
  - A requester holds valid and operands stable until ready.
  - Dropping valid before ready cancels the request with no side effects.

## Timing
- Reset values (asynchronous):
  - state = IDLE, `last` = 1.
  - Result register and latched operands = 0.
  - All `reqN_ready` = 0, all `rspN_valid` = 0, both `rspN_data` = 0, `busy` = 0.
- Latency: request accepted at edge T, so `rspN_valid` rises after edge T+1 (in the cycle following T+1).
- Minimum issue interval is 3 cycles: accept, EXEC, RESP with `rsp_ready` already high, then the next accept in the following IDLE cycle.
- `rspN_data` stays stable from `rspN_valid` rise until the handshake completes, and holds its value afterwards until the next EXEC.
- Simultaneous requests in IDLE: exactly one `reqN_ready` is high; the loser keeps valid and is granted in the next IDLE cycle.
- `rst` asserted mid-EXEC or mid-RESP: the pending result is discarded and no `rspN_valid` is issued after reset release.
- `rspN_ready` on the non-granted port is ignored.

## Test plan
- **Single add:** port 0 sends ctrl=000, a=5, b=4 from reset → `req0_ready` is high in the first cycle; `rsp0_valid` with data 9 arrives 2 cycles after accept; `rsp1_valid` stays 0.
- **Contention from reset:** both ports valid; port 0 sends sub a=749 b=619, port 1 sends xor a=-1488 b=-5942 → port 0 is granted first with result 130; port 1 is granted next with result (-1488 ^ -5942).
- **Round-robin:** both ports valid continuously over 6 operations → grants alternate 0,1,0,1,0,1.
- **Shifts:**
  - ctrl=111, a=-400, b=16 → -1 (0xFFFFFFFF).
  - ctrl=110, same operands → 0x0000FFFF.
  - ctrl=101, a=1048, b=13 → 8585216.
  - ctrl=101, a=1, b=40 → 0.
- **Back-pressure:** `rsp1_ready` held low for 5 cycles → `rsp1_valid` and `rsp1_data` stay stable and `busy` stays high throughout; a new `req0_valid` during this time sees `req0_ready` = 0.
- **Reset mid-operation:** `rst` pulsed during EXEC → all outputs return to their reset values immediately; no response is produced afterwards, and the next request completes normally.
